// File: rtl/stp_reg_if.sv
// Link-side bundle for the serial-to-parallel receive register:
// serial frame input plus the parallel valid/ready output and status pulses.
interface stp_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             in;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    output start, in, ready,
    input  data, valid, busy, frame_err, overrun
  );

  modport slave (
    input  start, in, ready,
    output data, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/stp_reg.sv
// SerDes RX serial-to-parallel register: shifts in MSB-first framed words and
// hands each completed word downstream through a one-deep valid/ready holding register.
module stp_reg #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  stp_reg_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             last_bit_c;
  logic             complete_c;
  logic [WIDTH-1:0] word_c;

  // The top bit of a word never needs storing: it leaves the window on the completion edge.
  assign last_bit_c = (cnt_q == CW'(WIDTH - 1));
  assign word_c     = {sr_q, bus.in};

  // Frame sequencing, word delivery and status pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.start && !last_bit_c) begin
          // Early start abandons the partial word; this cycle's bit is not sampled.
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          sr_d  = word_c[WIDTH-2:0];
          cnt_d = cnt_q + CW'(1);
          if (last_bit_c) begin
            complete_c = 1'b1;
            cnt_d      = '0;
            state_d    = bus.start ? SHIFT : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A full holding register only takes a new word if it is being consumed on this edge.
    if (complete_c) begin
      if (!valid_q || bus.ready) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_stp_reg.sv
// Bench for stp_reg: per-cycle stimulus queue, a bit-queue reference model feeding an
// expected-output scoreboard, and directed checks for framing, backpressure and reset.
module tb_stp_reg;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stp_reg_if #(.WIDTH(WIDTH)) bus();
  stp_reg #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic rst_n;
    logic start;
    logic in;
    logic ready;
  } item_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             busy;
    logic             fe;
    logic             ov;
  } snap_t;

  item_t       stim_q[$];
  snap_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  int          fe_cnt   = 0;
  int          ov_cnt   = 0;
  int          busy_cnt = 0;
  logic [31:0] got_w[$];
  longint      got_c[$];
  int          rmode    = 0;

  // Model state: frame in progress, bits collected so far, holding register.
  bit               m_act   = 1'b0;
  bit               m_bits[$];
  logic [WIDTH-1:0] m_data  = '0;
  logic             m_valid = 1'b0;

  function automatic logic rdy();
    if (rmode == 0) return 1'b0;
    if (rmode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push_item(logic r, logic s, logic i, logic rd);
    item_t it;
    it.rst_n = r; it.start = s; it.in = i; it.ready = rd;
    stim_q.push_back(it);
  endfunction

  function automatic void push_idle(int n);
    for (int k = 0; k < n; k++) push_item(1'b1, 1'b0, 1'($urandom_range(0, 1)), rdy());
  endfunction

  function automatic void push_rst();
    push_item(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  // Start strobe either gets its own cycle or rides on the previous frame's last bit.
  function automatic void push_frame(logic [WIDTH-1:0] w, int nbits, bit merge);
    item_t it;
    if (merge && stim_q.size() > 0) begin
      it = stim_q.pop_back();
      it.start = 1'b1;
      stim_q.push_back(it);
    end else begin
      push_item(1'b1, 1'b1, 1'($urandom_range(0, 1)), rdy());
    end
    for (int k = 0; k < nbits; k++) push_item(1'b1, 1'b0, w[WIDTH-1-k], rdy());
  endfunction

  function automatic void set_last_ready(logic rd);
    item_t it;
    it = stim_q.pop_back();
    it.ready = rd;
    stim_q.push_back(it);
  endfunction

  task automatic play();
    item_t it;
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      @(posedge clk);
      #2;
      rst_n     = it.rst_n;
      bus.start = it.start;
      bus.in    = it.in;
      bus.ready = it.ready;
    end
  endtask

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] gw(int k);
    if (k < got_w.size()) return got_w[k];
    return 'x;
  endfunction

  function automatic longint gc(int k);
    if (k < got_c.size()) return got_c[k];
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: collects frame bits in a queue and applies the delivery rules.
  initial forever begin : model
    logic [WIDTH-1:0] w;
    bit done, fe, ov;
    snap_t s;
    @(posedge clk);
    done = 1'b0; fe = 1'b0; ov = 1'b0; w = '0;
    if (!rst_n) begin
      m_act = 1'b0;
      m_bits.delete();
      m_data = '0;
      m_valid = 1'b0;
    end else begin
      if (m_act) begin
        if (bus.start && m_bits.size() < WIDTH - 1) begin
          m_bits.delete();
          fe = 1'b1;
        end else begin
          m_bits.push_back(bus.in);
          if (m_bits.size() == WIDTH) begin
            for (int k = 0; k < WIDTH; k++) w[WIDTH-1-k] = m_bits[k];
            done = 1'b1;
            m_bits.delete();
            m_act = bus.start;
          end
        end
      end else if (bus.start) begin
        m_act = 1'b1;
        m_bits.delete();
      end
      if (done) begin
        if (!m_valid || bus.ready) begin
          m_data  = w;
          m_valid = 1'b1;
        end else begin
          ov = 1'b1;
        end
      end else if (m_valid && bus.ready) begin
        m_valid = 1'b0;
      end
    end
    s.data = m_data; s.valid = m_valid; s.busy = m_act; s.fe = fe; s.ov = ov;
    exp_q.push_back(s);
  end

  // Monitor: compares every cycle against the model and logs transfers and pulses.
  initial forever begin : monitor
    snap_t e, g;
    @(negedge clk);
    g.data = bus.data; g.valid = bus.valid; g.busy = bus.busy;
    g.fe = bus.frame_err; g.ov = bus.overrun;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got data=%h v=%b b=%b fe=%b ov=%b required data=%h v=%b b=%b fe=%b ov=%b",
                 cyc, g.data, g.valid, g.busy, g.fe, g.ov, e.data, e.valid, e.busy, e.fe, e.ov);
      end
    end
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
      got_w.push_back(bus.data);
      got_c.push_back(cyc);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int b0, f0, o0;
    rst_n = 1'b0; bus.start = 1'b0; bus.in = 1'b0; bus.ready = 1'b0;

    rmode = 0;
    for (int k = 0; k < 3; k++) push_rst();
    push_idle(2);
    play();
    chk("reset_outputs", 64'({bus.data, bus.valid, bus.busy, bus.frame_err, bus.overrun}), 64'd0);

    // Single frame, no consumer.
    b0 = busy_cnt; f0 = fe_cnt; o0 = ov_cnt;
    push_frame(32'hA5C3_0F96, 32, 1'b0);
    push_idle(1);
    play();
    chk("t1_data", 64'(bus.data), 64'hA5C3_0F96);
    chk("t1_valid", 64'(bus.valid), 64'd1);
    chk("t1_busy_cycles", 64'(busy_cnt - b0), 64'd32);
    chk("t1_err_pulses", 64'((fe_cnt - f0) + (ov_cnt - o0)), 64'd0);

    // Back-to-back frames, consumer always ready.
    rmode = 1;
    push_idle(2);
    play();
    got_w.delete(); got_c.delete(); f0 = fe_cnt;
    push_frame(32'hFFFF_0000, 32, 1'b0);
    push_frame(32'h1234_5678, 32, 1'b1);
    push_idle(3);
    play();
    chk("t2_count", 64'(got_w.size()), 64'd2);
    chk("t2_word0", 64'(gw(0)), 64'hFFFF_0000);
    chk("t2_word1", 64'(gw(1)), 64'h1234_5678);
    chk("t2_spacing", 64'(gc(1) - gc(0)), 64'd32);
    chk("t2_frame_err", 64'(fe_cnt - f0), 64'd0);

    // Aborted frame followed by a full one.
    got_w.delete(); got_c.delete(); f0 = fe_cnt;
    push_frame(32'hDEAD_BEEF, 10, 1'b0);
    push_frame(32'h0000_0001, 32, 1'b0);
    push_idle(3);
    play();
    chk("t3_frame_err", 64'(fe_cnt - f0), 64'd1);
    chk("t3_count", 64'(got_w.size()), 64'd1);
    chk("t3_word", 64'(gw(0)), 64'h0000_0001);

    // Overrun: second word dropped while the first is held.
    rmode = 0;
    got_w.delete(); got_c.delete(); o0 = ov_cnt;
    push_frame(32'h1111_1111, 32, 1'b0);
    push_idle(2);
    push_frame(32'h2222_2222, 32, 1'b0);
    push_idle(2);
    play();
    chk("t4_overrun", 64'(ov_cnt - o0), 64'd1);
    chk("t4_data_kept", 64'(bus.data), 64'h1111_1111);
    chk("t4_valid_held", 64'(bus.valid), 64'd1);
    rmode = 1; push_idle(1);
    rmode = 0; push_idle(2);
    play();
    chk("t4_valid_cleared", 64'(bus.valid), 64'd0);
    chk("t4_consumed", 64'(gw(0)), 64'h1111_1111);

    // Consumer ready exactly on the completion edge: replace, no overrun.
    o0 = ov_cnt;
    push_frame(32'h1111_1111, 32, 1'b0);
    push_idle(2);
    push_frame(32'h2222_2222, 32, 1'b0);
    set_last_ready(1'b1);
    push_idle(2);
    play();
    chk("t5_data", 64'(bus.data), 64'h2222_2222);
    chk("t5_valid", 64'(bus.valid), 64'd1);
    chk("t5_overrun", 64'(ov_cnt - o0), 64'd0);

    // Reset mid-frame and while a word is held.
    rmode = 1; push_idle(2);
    rmode = 0;
    push_frame(32'hCAFE_F00D, 16, 1'b0);
    push_rst();
    push_idle(1);
    play();
    chk("t6_rst_frame", 64'({bus.data, bus.valid, bus.busy, bus.frame_err, bus.overrun}), 64'd0);
    push_frame(32'h1111_1111, 32, 1'b0);
    push_idle(1);
    play();
    chk("t6_held_before_rst", 64'(bus.valid), 64'd1);
    push_rst();
    push_idle(1);
    play();
    chk("t6_rst_held", 64'({bus.data, bus.valid, bus.busy, bus.frame_err, bus.overrun}), 64'd0);
    push_frame(32'h5A5A_3C3C, 32, 1'b0);
    push_idle(1);
    play();
    chk("t6_after_rst_data", 64'(bus.data), 64'h5A5A_3C3C);
    chk("t6_after_rst_valid", 64'(bus.valid), 64'd1);

    // Randomized traffic: aborts, back-to-back starts, random backpressure, resets.
    rmode = 2;
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 15));
      push_idle(int'($urandom_range(0, 3)));
      if (kind == 0) begin
        push_frame(32'($urandom), int'($urandom_range(1, 30)), 1'b0);
        push_rst();
      end else if (kind < 4) begin
        push_frame(32'($urandom), int'($urandom_range(1, 30)), 1'b0);
      end else begin
        push_frame(32'($urandom), 32, (kind > 10) ? 1'b1 : 1'b0);
      end
      play();
    end
    push_idle(5);
    play();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
